// File: rtl/input_multiplier_pkg.sv
// Shared constants, state encodings and digit payload for the BCD-to-binary input converter.
package input_multiplier_pkg;

  localparam int unsigned IM_N  = 14;
  localparam int unsigned BCD_W = 4;

  typedef enum logic [2:0] {
    S_C0 = 3'd0,
    S_C1 = 3'd1,
    S_C2 = 3'd2,
    S_C3 = 3'd3,
    S_FN = 3'd4
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] d3;
    logic [BCD_W-1:0] d2;
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } digits_t;

endpackage

// File: rtl/input_multiplier_mul10_add.sv
// Combinational acc*10 + digit step; overflow output exists only when IM_OVERFLOW_EN is defined.
module input_multiplier_mul10_add
  import input_multiplier_pkg::*;
#(
  parameter int unsigned N = IM_N
) (
  input  logic [N-1:0]     acc,
  input  logic [BCD_W-1:0] digit,
  output logic [N-1:0]     sum
`ifdef IM_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

`ifdef IM_OVERFLOW_EN
  localparam int unsigned W = N + BCD_W;

  logic [W-1:0] wide;

  // Widened by 4 bits so any carry out of the low N bits is visible as overflow
  always_comb begin
    wide = (W'(acc) << 3) + (W'(acc) << 1) + W'(digit);
    sum  = wide[N-1:0];
    ovf  = |wide[W-1:N];
  end
`else
  assign sum = (acc << 3) + (acc << 1) + N'(digit);
`endif

endmodule

// File: rtl/input_multiplier.sv
// Four-digit BCD to N-bit binary converter, one multiply-by-ten-and-add step per clock.
// Optional overflow reporting is enabled by defining IM_OVERFLOW_EN.
module input_multiplier
  import input_multiplier_pkg::*;
#(
  parameter int unsigned N = IM_N
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [BCD_W-1:0] bcd0,
  input  logic [BCD_W-1:0] bcd1,
  input  logic [BCD_W-1:0] bcd2,
  input  logic [BCD_W-1:0] bcd3,
  output logic [N-1:0]     data,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  state_t           state, state_d;
  digits_t          dig, dig_d;
  logic [N-1:0]     acc, acc_d;
  logic [N-1:0]     data_d;
  logic             valid_d;
  logic             busy_d;
  logic [BCD_W-1:0] cur_digit;
  logic [N-1:0]     step_sum;
`ifdef IM_OVERFLOW_EN
  logic             ovf, ovf_d;
  logic             overflow_d;
  logic             step_ovf;
`endif

  // Digit consumed by the current step, most significant first
  always_comb begin
    cur_digit = dig.d0;
    case (state)
      S_C3:    cur_digit = dig.d3;
      S_C2:    cur_digit = dig.d2;
      S_C1:    cur_digit = dig.d1;
      default: cur_digit = dig.d0;
    endcase
  end

  input_multiplier_mul10_add #(.N(N)) u_step (
    .acc   (acc),
    .digit (cur_digit),
    .sum   (step_sum)
`ifdef IM_OVERFLOW_EN
    ,
    .ovf   (step_ovf)
`endif
  );

  // Next-state and next-output logic; load overrides any in-flight conversion
  always_comb begin
    state_d = state;
    dig_d   = dig;
    acc_d   = acc;
    data_d  = data;
    valid_d = 1'b0;
`ifdef IM_OVERFLOW_EN
    ovf_d      = ovf;
    overflow_d = overflow;
`endif
    if (load) begin
      dig_d   = '{d3: bcd3, d2: bcd2, d1: bcd1, d0: bcd0};
      acc_d   = '0;
      state_d = S_C3;
`ifdef IM_OVERFLOW_EN
      ovf_d = 1'b0;
`endif
    end else begin
      case (state)
        S_C3, S_C2, S_C1: begin
          acc_d   = step_sum;
          state_d = (state == S_C3) ? S_C2 : (state == S_C2) ? S_C1 : S_C0;
`ifdef IM_OVERFLOW_EN
          ovf_d = ovf | step_ovf;
`endif
        end
        S_C0: begin
          data_d  = step_sum;
          valid_d = 1'b1;
          state_d = S_FN;
`ifdef IM_OVERFLOW_EN
          overflow_d = ovf | step_ovf;
`endif
        end
        default: state_d = S_FN;
      endcase
    end
    busy_d = (state_d != S_FN);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_FN;
      dig   <= '0;
      acc   <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
`ifdef IM_OVERFLOW_EN
      ovf      <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      state <= state_d;
      dig   <= dig_d;
      acc   <= acc_d;
      data  <= data_d;
      valid <= valid_d;
      busy  <= busy_d;
`ifdef IM_OVERFLOW_EN
      ovf      <= ovf_d;
      overflow <= overflow_d;
`endif
    end
  end

`ifndef IM_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_input_multiplier.sv
// Self-checking bench for input_multiplier: N=14 and N=10 instances share stimulus; scoreboard of expected values.
module tb_input_multiplier;

`ifdef IM_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       load  = 1'b0;
  logic [3:0] bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0;
  logic [13:0] data14;
  logic [9:0]  data10;
  logic        valid14, busy14, ovf14;
  logic        valid10, busy10, ovf10;

  typedef struct {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    int         value;
  } vec_t;

  vec_t vecs[10];
  int   q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 Clock = ~Clock;

  input_multiplier #(.N(14)) dut14 (
    .Clock(Clock), .Reset(Reset), .load(load),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .data(data14), .valid(valid14), .busy(busy14), .overflow(ovf14)
  );

  input_multiplier #(.N(10)) dut10 (
    .Clock(Clock), .Reset(Reset), .load(load),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .data(data10), .valid(valid10), .busy(busy10), .overflow(ovf10)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int val);
    vec_t v;
    v.d3 = 4'(a); v.d2 = 4'(b); v.d1 = 4'(c); v.d0 = 4'(d); v.value = val;
    return v;
  endfunction

  // Scoreboard: every valid pulse must match the oldest outstanding expectation
  always @(negedge Clock) begin : mon
    int v;
    if (valid14 || valid10) begin
      chk("valid_n10_vs_n14", valid10, valid14);
      if (q.size() == 0) begin
        chk("unexpected_valid", valid14, 0);
      end else begin
        v = q.pop_front();
        chk("data_n14", data14, v % 16384);
        chk("overflow_n14", ovf14, OVF_EN && (v >= 16384));
        chk("data_n10", data10, v % 1024);
        chk("overflow_n10", ovf10, OVF_EN && (v >= 1024));
      end
    end
  end

  // Called at a falling edge: pulses load for one cycle, returns one falling edge later
  task automatic drive(input vec_t v, input bit push);
    load = 1'b1;
    bcd3 = v.d3; bcd2 = v.d2; bcd1 = v.d1; bcd0 = v.d0;
    if (push) q.push_back(v.value);
    @(negedge Clock);
    load = 1'b0;
  endtask

  // Full conversion with latency and busy-duration checks; returns at the valid cycle
  task automatic run_vec(input vec_t v);
    int n;
    int busy_n;
    drive(v, 1'b1);
    n = 1;
    busy_n = int'(busy14);
    while (!valid14 && n < 12) begin
      @(negedge Clock);
      n++;
      if (!valid14) busy_n += int'(busy14);
    end
    chk("latency", n, 5);
    chk("busy_cycles", busy_n, 4);
    chk("busy_at_valid", busy14, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(1, 2, 3, 4, 1234);
    vecs[1] = mk(9, 9, 9, 9, 9999);
    vecs[2] = mk(0, 0, 0, 0, 0);
    vecs[3] = mk(1, 0, 2, 4, 1024);
    vecs[4] = mk(15, 15, 15, 15, 16665);
    vecs[5] = mk(10, 0, 0, 0, 10000);
    vecs[6] = mk(6, 5, 5, 3, 6553);
    vecs[7] = mk(1, 6, 3, 8, 1638);
    vecs[8] = mk(0, 0, 4, 2, 42);
    vecs[9] = mk(0, 0, 0, 7, 7);

    #2 Reset = 1'b0;
    #10;
    chk("reset_data", data14, 0);
    chk("reset_valid", valid14, 0);
    chk("reset_busy", busy14, 0);
    chk("reset_overflow", ovf14, 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      @(negedge Clock);
    end

    // Reload in the valid cycle: first result intact, second follows normally
    run_vec(mk(1, 2, 3, 4, 1234));
    run_vec(mk(0, 0, 0, 7, 7));
    @(negedge Clock);

    // Reload while busy: abandoned conversion must never produce a pulse
    drive(mk(5, 5, 5, 5, 5555), 1'b0);
    @(negedge Clock);
    run_vec(mk(0, 0, 4, 2, 42));
    repeat (6) @(negedge Clock);
    chk("idle_hold_data", data14, 42);
    chk("idle_busy", busy14, 0);

    // Asynchronous reset while in the hundreds-digit step
    drive(mk(9, 9, 9, 9, 9999), 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("midreset_data", data14, 0);
    chk("midreset_valid", valid14, 0);
    chk("midreset_busy", busy14, 0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (8) @(negedge Clock);
    chk("postreset_data", data14, 0);
    chk("postreset_busy", busy14, 0);

    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
